mem_arbiter: RTL and testbench

//  Parametrised memory front-end: arbitrates NCH word-level requesters (instruction fetch,

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter_rr_arbiter.sv | 31 +++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-serial memory arbiter: access sizes, FSM states
// and the size-to-byte-count decode.
package mem_arbiter_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // The unused encoding 3 is deliberately decoded as a full word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   len_bytes = 3'd1;
      LEN_H:   len_bytes = 3'd2;
      default: len_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after ptr_i,
// wrapping at NCH. Returns both a one-hot grant and its index.
module mem_arbiter_rr_arbiter #(
  parameter int NCH   = 2,
  parameter int PTR_W = 1
) (
  input  logic [NCH-1:0]   req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NCH-1:0]   gnt_o,
  output logic [PTR_W-1:0] gnt_idx_o
);

  int j;

  // Scan from the farthest offset down so the closest requester to ptr_i wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    j         = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      j = int'(ptr_i) + i;
      if (j >= NCH) j = j - NCH;
      if (req_i[j]) begin
        gnt_o     = '0;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-serial memory front-end: round-robin arbitration of NCH word-level
// requesters onto one byte-wide synchronous RAM port with RD_LAT read latency.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        req_i,
  input  logic [NCH-1:0]        we_i,
  input  logic [2*NCH-1:0]      len_i,
  input  logic [ADDR_W*NCH-1:0] addr_i,
  input  logic [32*NCH-1:0]     wdata_i,
  output logic [31:0]           rdata_o,
  output logic [NCH-1:0]        done_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [7:0]            mem_dout_o,
  output logic                  mem_wr_o,
  input  logic [7:0]            mem_din_i
);

  // state    | meaning
  // ST_IDLE  | wait for any request, grant and latch one channel
  // ST_XFER  | issue one byte per cycle at addr+k
  // ST_DRAIN | reads only: collect bytes still in the RAM pipeline
  // ST_DONE  | pulse done_o of the granted channel, advance rr pointer

  localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int LAT_W = $clog2(RD_LAT + 1);

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    grant_q, grant_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                we_q, we_d;
  logic [2:0]          nbytes_q, nbytes_d;
  logic [2:0]          tx_left_q, tx_left_d;
  logic [2:0]          rx_idx_q, rx_idx_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         asm_q, asm_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [NCH-1:0]      arb_gnt;
  logic [PTR_W-1:0]    arb_idx;

  mem_arbiter_rr_arbiter #(
    .NCH   (NCH),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req_i     (req_i),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    we_d      = we_q;
    nbytes_d  = nbytes_q;
    tx_left_d = tx_left_q;
    rx_idx_d  = rx_idx_q;
    lat_cnt_d = lat_cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    asm_d     = asm_q;
    rdata_d   = rdata_q;

    if (lat_cnt_q != '0) lat_cnt_d = lat_cnt_q - LAT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (|arb_gnt) begin
          grant_d   = arb_idx;
          we_d      = we_i[arb_idx];
          nbytes_d  = len_bytes(len_i[2*arb_idx +: 2]);
          tx_left_d = len_bytes(len_i[2*arb_idx +: 2]);
          addr_d    = addr_i[ADDR_W*arb_idx +: ADDR_W];
          wdata_d   = wdata_i[32*arb_idx +: 32];
          asm_d     = '0;
          rx_idx_d  = '0;
          lat_cnt_d = LAT_W'(RD_LAT);
          state_d   = ST_XFER;
        end
      end
      ST_XFER: begin
        addr_d    = addr_q + ADDR_W'(1);
        wdata_d   = wdata_q >> BYTE_W;
        tx_left_d = tx_left_q - 3'd1;
        if (tx_left_q == 3'd1) state_d = we_q ? ST_DONE : ST_DRAIN;
      end
      ST_DRAIN: ;
      ST_DONE: begin
        rr_ptr_d = (int'(grant_q) == NCH - 1) ? '0 : grant_q + PTR_W'(1);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Reads issue back-to-back, so once the first byte's latency has elapsed
    // one byte returns every cycle until all have arrived.
    if (!we_q && lat_cnt_q == '0 && rx_idx_q != nbytes_q &&
        (state_q == ST_XFER || state_q == ST_DRAIN)) begin
      asm_d[BYTE_W*rx_idx_q[1:0] +: BYTE_W] = mem_din_i;
      rx_idx_d = rx_idx_q + 3'd1;
      if (rx_idx_q == nbytes_q - 3'd1) begin
        rdata_d = asm_d;
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      we_q      <= 1'b0;
      nbytes_q  <= '0;
      tx_left_q <= '0;
      rx_idx_q  <= '0;
      lat_cnt_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      asm_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      we_q      <= we_d;
      nbytes_q  <= nbytes_d;
      tx_left_q <= tx_left_d;
      rx_idx_q  <= rx_idx_d;
      lat_cnt_q <= lat_cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      asm_q     <= asm_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    done_o = '0;
    if (state_q == ST_DONE) done_o[grant_q] = 1'b1;
  end

  assign mem_wr_o   = (state_q == ST_XFER) && we_q;
  assign mem_addr_o = addr_q;
  assign mem_dout_o = mem_wr_o ? wdata_q[7:0] : 8'h00;
  assign rdata_o    = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// batches, checked against a transaction-level RAM and round-robin model.
module tb_mem_arbiter;

  localparam int NCH    = 3;
  localparam int RD_LAT = 3;

  typedef struct packed {
    logic        we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    req_i, we_i;
  logic [2*NCH-1:0]  len_i;
  logic [32*NCH-1:0] addr_i, wdata_i;
  logic [31:0]       rdata_o;
  logic [NCH-1:0]    done_o;
  logic [31:0]       mem_addr_o;
  logic [7:0]        mem_dout_o;
  logic              mem_wr_o;
  logic [7:0]        mem_din_i;

  logic              pre_we;
  logic [11:0]       pre_addr;
  logic [7:0]        pre_data;
  logic [7:0]        ram   [4096];
  logic [7:0]        dpipe [RD_LAT];
  logic [39:0]       wlog [$];
  int                cyc = 0;

  logic [7:0]        ref_mem [4096];
  op_t               opq [NCH][$];
  op_t               cur [NCH];
  int                obs_order [$];
  int                model_ptr;
  int                n_checks = 0;
  int                n_fail = 0;

  mem_arbiter #(.NCH(NCH), .ADDR_W(32), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .we_i       (we_i),
    .len_i      (len_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .done_o     (done_o),
    .mem_addr_o (mem_addr_o),
    .mem_dout_o (mem_dout_o),
    .mem_wr_o   (mem_wr_o),
    .mem_din_i  (mem_din_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM: 4 KiB aliased over the address space, read data RD_LAT cycles late.
  always @(posedge clk) begin
    if (mem_wr_o) ram[mem_addr_o[11:0]] <= mem_dout_o;
    else if (pre_we) ram[pre_addr] <= pre_data;
    dpipe[0] <= ram[mem_addr_o[11:0]];
    for (int i = 1; i < RD_LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign mem_din_i = dpipe[RD_LAT-1];

  always @(negedge clk) if (mem_wr_o) wlog.push_back({mem_addr_o, mem_dout_o});

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk_op(input logic we, input logic [1:0] len,
                                input logic [31:0] addr, input logic [31:0] wdata);
    op_t o;
    o.we = we; o.len = len; o.addr = addr; o.wdata = wdata;
    return o;
  endfunction

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  task automatic drive_op(input int ch, input op_t op);
    we_i[ch]            = op.we;
    len_i[2*ch +: 2]    = op.len;
    addr_i[32*ch +: 32] = op.addr;
    wdata_i[32*ch +: 32] = op.wdata;
    req_i[ch]           = 1'b1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] b);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = b;
    @(negedge clk);
    pre_we = 1'b0;
    ref_mem[a] = b;
  endtask

  // Runs every queued op to completion; grant order, spacing, data and write
  // bytes are all predicted from the queues and the byte-array RAM model.
  task automatic run_batch(input bit scramble);
    int order [$];
    int cnt [NCH];
    int p, idx, prev, budget, ch, act, nb, lat, c2;
    bit any;
    op_t op;
    logic [31:0] exp, a;
    logic [39:0] e;

    obs_order.delete();
    p = model_ptr;
    for (int c = 0; c < NCH; c++) cnt[c] = opq[c].size();
    do begin
      any = 1'b0;
      for (int k = 0; k < NCH; k++) begin
        c2 = (p + k) % NCH;
        if (!any && cnt[c2] > 0) begin
          any = 1'b1;
          order.push_back(c2);
          cnt[c2]--;
          p = (c2 + 1) % NCH;
        end
      end
    end while (any);

    @(negedge clk);
    for (int c = 0; c < NCH; c++)
      if (opq[c].size() > 0) begin
        cur[c] = opq[c].pop_front();
        drive_op(c, cur[c]);
      end
    prev   = cyc - 1;
    idx    = 0;
    budget = 30 * order.size() + 40;
    while (idx < order.size() && budget > 0) begin
      @(negedge clk);
      budget--;
      check("done_onehot", 40'($onehot0(done_o)), 40'd1);
      if (done_o != '0) begin
        ch = 0;
        for (int c = NCH - 1; c >= 0; c--) if (done_o[c]) ch = c;
        obs_order.push_back(ch);
        check("grant_order", 40'(ch), 40'(order[idx]));
        op  = cur[ch];
        nb  = nbytes(op.len);
        lat = op.we ? nb + 1 : nb + RD_LAT + 1;
        check("done_spacing", 40'(cyc - prev), 40'(lat + 1));
        if (op.we) begin
          for (int k = 0; k < nb; k++) begin
            a = op.addr + 32'(k);
            if (wlog.size() == 0) check("wlog_count", 40'(k), 40'(nb));
            else begin
              e = wlog.pop_front();
              check("wr_addr", 40'(e[39:8]), 40'(a));
              check("wr_byte", 40'(e[7:0]), 40'(op.wdata[8*k +: 8]));
            end
            ref_mem[a[11:0]] = op.wdata[8*k +: 8];
          end
        end else begin
          exp = '0;
          for (int k = 0; k < nb; k++) begin
            a = op.addr + 32'(k);
            exp[8*k +: 8] = ref_mem[a[11:0]];
          end
          check("rdata", 40'(rdata_o), 40'(exp));
        end
        model_ptr = (ch + 1) % NCH;
        prev = cyc;
        idx++;
        if (opq[ch].size() > 0) begin
          cur[ch] = opq[ch].pop_front();
          drive_op(ch, cur[ch]);
        end else req_i[ch] = 1'b0;
      end else if (scramble && idx < order.size() && cyc >= prev + 2) begin
        act = order[idx];
        addr_i[32*act +: 32]  = $urandom;
        wdata_i[32*act +: 32] = $urandom;
        len_i[2*act +: 2]     = 2'($urandom_range(0, 3));
        we_i[act]             = 1'($urandom_range(0, 1));
        req_i[act]            = 1'($urandom_range(0, 1));
      end
    end
    check("batch_complete", 40'(idx), 40'(order.size()));
    check("wlog_extra", 40'(wlog.size()), 40'd0);
    @(negedge clk);
    check("done_single", 40'(done_o), 40'd0);
  endtask

  initial begin
    int n_ops;
    rst_n = 1'b0;
    req_i = '0; we_i = '0; len_i = '0; addr_i = '0; wdata_i = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    model_ptr = 0;
    repeat (3) @(negedge clk);
    check("rst_done", 40'(done_o), 40'd0);
    check("rst_wr", 40'(mem_wr_o), 40'd0);
    check("rst_addr", 40'(mem_addr_o), 40'd0);
    check("rst_dout", 40'(mem_dout_o), 40'd0);
    check("rst_rdata", 40'(rdata_o), 40'd0);
    rst_n = 1'b1;

    // 4-byte read, little-endian assembly
    for (int k = 0; k < 4; k++) preload(12'h100 + 12'(k), 8'(8'h11 * (k + 1)));
    opq[0].push_back(mk_op(1'b0, 2'd2, 32'h100, 32'h0));
    run_batch(1'b0);
    check("s1_rdata", 40'(rdata_o), 40'h44332211);

    // halfword write then byte read-back on the same channel
    opq[1].push_back(mk_op(1'b1, 2'd1, 32'h20, 32'h0000BEEF));
    opq[1].push_back(mk_op(1'b0, 2'd0, 32'h21, 32'h0));
    run_batch(1'b0);
    check("s2_rdata", 40'(rdata_o), 40'h000000BE);

    // simultaneous requests, ch0 re-requests immediately
    opq[0].push_back(mk_op(1'b0, 2'd2, 32'h100, 32'h0));
    opq[0].push_back(mk_op(1'b0, 2'd1, 32'h20, 32'h0));
    opq[1].push_back(mk_op(1'b0, 2'd0, 32'h21, 32'h0));
    run_batch(1'b0);
    check("s3_n", 40'(obs_order.size()), 40'd3);
    if (obs_order.size() == 3) begin
      check("s3_first", 40'(obs_order[0]), 40'd0);
      check("s3_second", 40'(obs_order[1]), 40'd1);
      check("s3_third", 40'(obs_order[2]), 40'd0);
    end

    // all channels requesting continuously; pointer sits at 1 after the last grant to 0
    for (int c = 0; c < NCH; c++) begin
      opq[c].push_back(mk_op(1'b0, 2'd0, 32'h100 + 32'(c), 32'h0));
      opq[c].push_back(mk_op(1'b1, 2'd0, 32'h40 + 32'(c), 32'(c + 8'hA0)));
    end
    run_batch(1'b0);
    check("s4_n", 40'(obs_order.size()), 40'd6);
    if (obs_order.size() == 6)
      for (int i = 0; i < 6; i++) check("s4_rr", 40'(obs_order[i]), 40'((i + 1) % 3));

    // address wrap at the top of the space
    opq[2].push_back(mk_op(1'b1, 2'd2, 32'hFFFFFFFE, 32'h0A0B0C0D));
    opq[2].push_back(mk_op(1'b0, 2'd3, 32'hFFFFFFFE, 32'h0));
    run_batch(1'b0);
    check("s5_rdata", 40'(rdata_o), 40'h0A0B0C0D);

    // reset in the middle of a word write
    for (int k = 0; k < 4; k++) preload(12'h200 + 12'(k), 8'(8'h55 + 8'h11 * k));
    wlog.delete();
    @(negedge clk);
    drive_op(0, mk_op(1'b1, 2'd2, 32'h200, 32'hA1B2C3D4));
    @(negedge clk);
    @(negedge clk);
    #2;
    check("pre_rst_wr", 40'(mem_wr_o), 40'd1);
    rst_n = 1'b0;
    #1;
    check("arst_wr", 40'(mem_wr_o), 40'd0);
    check("arst_addr", 40'(mem_addr_o), 40'd0);
    check("arst_done", 40'(done_o), 40'd0);
    check("arst_rdata", 40'(rdata_o), 40'd0);
    check("arst_strobes", 40'(wlog.size()), 40'd2);
    req_i = '0;
    repeat (3) begin
      @(negedge clk);
      check("arst_nodone", 40'(done_o), 40'd0);
    end
    rst_n = 1'b1;
    model_ptr = 0;
    ref_mem[12'h200] = 8'hD4;
    wlog.delete();
    opq[0].push_back(mk_op(1'b0, 2'd2, 32'h200, 32'h0));
    opq[1].push_back(mk_op(1'b0, 2'd0, 32'h100, 32'h0));
    run_batch(1'b0);
    check("s6_first", 40'(obs_order.size() > 0 ? obs_order[0] : -1), 40'd0);

    // randomized batches with post-grant input disturbance
    for (int k = 0; k < 68; k++) preload(12'h300 + 12'(k), 8'($urandom));
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < NCH; c++) begin
        n_ops = $urandom_range(1, 5);
        for (int i = 0; i < n_ops; i++)
          opq[c].push_back(mk_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                                 32'h300 + 32'($urandom_range(0, 63)), $urandom));
      end
      run_batch(1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
